// File: rtl/param_shift_register_if.sv
// Bus bundle for param_shift_register: mode/data/serial inputs and register outputs.
// There is no valid/ready handshake: the sampled mode is applied on every rising edge.
interface param_shift_register_if #(
    parameter int WIDTH = 8
) ();
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             sout_lsb;
    logic             sout_msb;
    logic             busy;
    logic             done;
    logic             dbg_state;

    modport master (
        output mode, d, sin_msb, sin_lsb,
        input  Q, Qb, sout_lsb, sout_msb, busy, done, dbg_state
    );

    modport slave (
        input  mode, d, sin_msb, sin_lsb,
        output Q, Qb, sout_lsb, sout_msb, busy, done, dbg_state
    );
endinterface

// File: rtl/param_shift_register.sv
// WIDTH-bit hold/shift/load register with a load-triggered shift counter (busy/done).
// Optional macro SHIFT_ROTATE_EN turns serial-in shifts into rotates.
module param_shift_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic                  clk,
    input logic                  rst_n,
    param_shift_register_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_in_msb;
    logic             w_in_lsb;
    logic             w_shift;

`ifdef SHIFT_ROTATE_EN
    assign w_in_msb = r_q[0];
    assign w_in_lsb = r_q[WIDTH-1];
`else
    assign w_in_msb = bus.sin_msb;
    assign w_in_lsb = bus.sin_lsb;
`endif

    assign w_shift = (bus.mode == 2'b01) || (bus.mode == 2'b10);

    always_comb begin
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (bus.mode)
            2'b01:   w_q_next = {w_in_msb, r_q[WIDTH-1:1]};
            2'b10:   w_q_next = {r_q[WIDTH-2:0], w_in_lsb};
            2'b11:   w_q_next = bus.d;
            default: w_q_next = r_q;
        endcase
        // A load always (re)starts the count; only shifts in ACTIVE advance it.
        if (bus.mode == 2'b11) begin
            w_cnt_next   = '0;
            w_state_next = ACTIVE;
        end else if (w_shift && (r_state == ACTIVE)) begin
            if (r_cnt == CW'(WIDTH - 1)) begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= RESET_VAL;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.Q         = r_q;
    assign bus.Qb        = ~r_q;
    assign bus.sout_lsb  = r_q[0];
    assign bus.sout_msb  = r_q[WIDTH-1];
    assign bus.busy      = (r_state == ACTIVE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_param_shift_register.sv
// Directed-vector bench for param_shift_register with a queued scoreboard and negedge monitor.
module tb_param_shift_register;
    localparam int W  = 8;
    localparam int EW = 2 * W + 4;

    logic clk;
    logic rst_n;

    param_shift_register_if #(.WIDTH(W)) bus ();

    param_shift_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        string         nm;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {bus.Q, bus.Qb, bus.sout_msb, bus.sout_lsb, bus.busy, bus.done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got Q=%h Qb=%h smsb=%b slsb=%b busy=%b done=%b, want Q=%h Qb=%h smsb=%b slsb=%b busy=%b done=%b",
                         nm, act_v[EW-1 -: W], act_v[W+3 -: W], act_v[3], act_v[2], act_v[1], act_v[0],
                         exp_v[EW-1 -: W], exp_v[W+3 -: W], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // driver
    task automatic step(input string nm, input logic rst, input logic [1:0] m,
                        input logic [W-1:0] dd, input logic smsb, input logic slsb,
                        input logic [W-1:0] eq, input logic eb, input logic ed);
        rst_n       = rst;
        bus.mode    = m;
        bus.d       = dd;
        bus.sin_msb = smsb;
        bus.sin_lsb = slsb;
        @(posedge clk);
        exp_q.push_back({eq, ~eq, eq[W-1], eq[0], eb, ed});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.mode    = 2'b00;
        bus.d       = '0;
        bus.sin_msb = 1'b0;
        bus.sin_lsb = 1'b0;
        @(negedge clk);

        step("reset_over_load", 0, 2'b11, 8'hA5, 0, 0, 8'h00, 0, 0);
`ifdef SHIFT_ROTATE_EN
        step("rot_load81",  1, 2'b11, 8'h81, 0, 0, 8'h81, 1, 0);
        step("rot_l1",      1, 2'b10, 8'h00, 0, 0, 8'h03, 1, 0);
        step("rot_l2",      1, 2'b10, 8'h00, 1, 1, 8'h06, 1, 0);
        step("rot_l3",      1, 2'b10, 8'h00, 0, 0, 8'h0C, 1, 0);
        step("rot_hold",    1, 2'b00, 8'h00, 0, 0, 8'h0C, 1, 0);
        step("rot_l4",      1, 2'b10, 8'h00, 0, 0, 8'h18, 1, 0);
        step("rot_l5",      1, 2'b10, 8'h00, 0, 0, 8'h30, 1, 0);
        step("rot_l6",      1, 2'b10, 8'h00, 0, 0, 8'h60, 1, 0);
        step("rot_l7",      1, 2'b10, 8'h00, 0, 0, 8'hC0, 1, 0);
        step("rot_l8_done", 1, 2'b10, 8'h00, 0, 0, 8'h81, 0, 1);
        step("rot_after",   1, 2'b00, 8'h00, 0, 0, 8'h81, 0, 0);
        step("rot_load81b", 1, 2'b11, 8'h81, 0, 0, 8'h81, 1, 0);
        step("rot_r1",      1, 2'b01, 8'h00, 0, 0, 8'hC0, 1, 0);
        step("rot_r2",      1, 2'b01, 8'h00, 1, 1, 8'h60, 1, 0);
`else
        step("load_a5",     1, 2'b11, 8'hA5, 0, 0, 8'hA5, 1, 0);
        step("hold1",       1, 2'b00, 8'h3C, 1, 1, 8'hA5, 1, 0);
        step("hold2",       1, 2'b00, 8'h3C, 1, 1, 8'hA5, 1, 0);
        step("hold3",       1, 2'b00, 8'h3C, 1, 1, 8'hA5, 1, 0);
        step("shr_sin1",    1, 2'b01, 8'h00, 1, 0, 8'hD2, 1, 0);
        step("reload_a5",   1, 2'b11, 8'hA5, 0, 0, 8'hA5, 1, 0);
        step("shl_sin0",    1, 2'b10, 8'h00, 1, 0, 8'h4A, 1, 0);
        step("load_81",     1, 2'b11, 8'h81, 0, 0, 8'h81, 1, 0);
        step("cnt_s1",      1, 2'b01, 8'h00, 0, 1, 8'h40, 1, 0);
        step("cnt_h1",      1, 2'b00, 8'h00, 0, 1, 8'h40, 1, 0);
        step("cnt_s2",      1, 2'b01, 8'h00, 0, 1, 8'h20, 1, 0);
        step("cnt_s3",      1, 2'b01, 8'h00, 0, 1, 8'h10, 1, 0);
        step("cnt_h2",      1, 2'b00, 8'h00, 0, 1, 8'h10, 1, 0);
        step("cnt_s4",      1, 2'b01, 8'h00, 0, 1, 8'h08, 1, 0);
        step("cnt_s5",      1, 2'b01, 8'h00, 0, 1, 8'h04, 1, 0);
        step("cnt_s6",      1, 2'b01, 8'h00, 0, 1, 8'h02, 1, 0);
        step("cnt_h3",      1, 2'b00, 8'h00, 0, 1, 8'h02, 1, 0);
        step("cnt_s7",      1, 2'b01, 8'h00, 0, 1, 8'h01, 1, 0);
        step("cnt_s8_done", 1, 2'b01, 8'h00, 0, 1, 8'h00, 0, 1);
        step("done_clear",  1, 2'b00, 8'h00, 0, 1, 8'h00, 0, 0);
        step("idle_shr",    1, 2'b01, 8'h00, 1, 0, 8'h80, 0, 0);
        step("idle_shl",    1, 2'b10, 8'h00, 0, 1, 8'h01, 0, 0);
        step("idle_r1",     1, 2'b01, 8'h00, 1, 0, 8'h80, 0, 0);
        step("idle_r2",     1, 2'b01, 8'h00, 1, 0, 8'hC0, 0, 0);
        step("idle_r3",     1, 2'b01, 8'h00, 1, 0, 8'hE0, 0, 0);
        step("idle_r4",     1, 2'b01, 8'h00, 1, 0, 8'hF0, 0, 0);
        step("idle_r5",     1, 2'b01, 8'h00, 1, 0, 8'hF8, 0, 0);
        step("idle_r6",     1, 2'b01, 8'h00, 1, 0, 8'hFC, 0, 0);
        step("idle_r7",     1, 2'b01, 8'h00, 1, 0, 8'hFE, 0, 0);
        step("idle_r8",     1, 2'b01, 8'h00, 1, 0, 8'hFF, 0, 0);
        // Reset in the middle of a count must abort it without a done pulse.
        step("abort_load",  1, 2'b11, 8'h81, 0, 0, 8'h81, 1, 0);
        step("abort_s1",    1, 2'b01, 8'h00, 0, 0, 8'h40, 1, 0);
        step("abort_s2",    1, 2'b01, 8'h00, 0, 0, 8'h20, 1, 0);
        step("abort_s3",    1, 2'b01, 8'h00, 0, 0, 8'h10, 1, 0);
        step("abort_rst",   0, 2'b01, 8'h00, 1, 1, 8'h00, 0, 0);
        step("post_rst_s1", 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0);
        step("post_rst_s2", 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0);
        step("post_rst_s3", 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0);
        step("post_rst_s4", 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0);
        step("post_rst_s5", 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0);
        step("re_load_3c",  1, 2'b11, 8'h3C, 0, 0, 8'h3C, 1, 0);
        step("re_l1",       1, 2'b10, 8'h00, 0, 0, 8'h78, 1, 0);
        step("re_l2",       1, 2'b10, 8'h00, 0, 0, 8'hF0, 1, 0);
        step("re_l3",       1, 2'b10, 8'h00, 0, 0, 8'hE0, 1, 0);
        step("re_l4",       1, 2'b10, 8'h00, 0, 0, 8'hC0, 1, 0);
        step("mid_reload",  1, 2'b11, 8'h81, 0, 0, 8'h81, 1, 0);
        step("mid_l1",      1, 2'b10, 8'h00, 0, 0, 8'h02, 1, 0);
        step("mid_l2",      1, 2'b10, 8'h00, 0, 0, 8'h04, 1, 0);
        step("mid_l3",      1, 2'b10, 8'h00, 0, 0, 8'h08, 1, 0);
        step("mid_l4",      1, 2'b10, 8'h00, 0, 0, 8'h10, 1, 0);
        step("mid_l5",      1, 2'b10, 8'h00, 0, 0, 8'h20, 1, 0);
        step("mid_l6",      1, 2'b10, 8'h00, 0, 0, 8'h40, 1, 0);
        step("mid_l7",      1, 2'b10, 8'h00, 0, 0, 8'h80, 1, 0);
        step("mid_l8_done", 1, 2'b10, 8'h00, 0, 0, 8'h00, 0, 1);
        step("mid_after",   1, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0);
        step("mix_load",    1, 2'b11, 8'h0F, 0, 0, 8'h0F, 1, 0);
        step("mix_l1",      1, 2'b10, 8'h00, 0, 0, 8'h1E, 1, 0);
        step("mix_r2",      1, 2'b01, 8'h00, 1, 0, 8'h8F, 1, 0);
        step("mix_l3",      1, 2'b10, 8'h00, 0, 1, 8'h1F, 1, 0);
        step("mix_r4",      1, 2'b01, 8'h00, 0, 0, 8'h0F, 1, 0);
        step("mix_l5",      1, 2'b10, 8'h00, 0, 0, 8'h1E, 1, 0);
        step("mix_r6",      1, 2'b01, 8'h00, 0, 0, 8'h0F, 1, 0);
        step("mix_l7",      1, 2'b10, 8'h00, 0, 0, 8'h1E, 1, 0);
        step("mix_r8_done", 1, 2'b01, 8'h00, 0, 0, 8'h0F, 0, 1);
        step("mix_after",   1, 2'b01, 8'h00, 0, 0, 8'h07, 0, 0);
`endif
        bus.mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
